reorder_buffer: RTL and testbench

- Circular in-order reorder buffer between dispatcher/CDB and the register file.
- Allocates one rename tag per dispatched instruction and captures results from the common data bus (CDB).
- Retires at most one completed instruction per cycle to the RF and store path, in program order.
- On a mispredicted branch reaching the head, flushes all speculative state and drives `wrong_commit` plus the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 52 +++++
 rtl/rob_query_port.sv | 62 ++++++
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// Module   : reorder_buffer_pkg
// Brief    : Shared constants, entry layout and tag helpers for the ROB slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reorder_buffer_pkg;

  // Tag 0 is reserved for "no dependency", so depth is capped at 31.
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = $clog2(ROB_DEPTH + 1);

  localparam logic [1:0] ROB_ALU = 2'd0;
  localparam logic [1:0] ROB_BR  = 2'd1;
  localparam logic [1:0] ROB_ST  = 2'd2;

  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        mispred;
    logic [4:0]  rd;
    logic [1:0]  typ;
    logic [31:0] value;
    logic [31:0] redirect_pc;
  } rob_entry_t;

  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
    return (tag != NO_TAG) && (int'(tag) <= ROB_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] t;
    t = tag - TAG_W'(1);
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(idx) + TAG_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == ROB_DEPTH - 1) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob_query_port.sv
// ============================================================================
// Module   : rob_query_port
// Brief    : Combinational operand lookup by rename tag; with ROB_CDB_FORWARD_EN
//            defined, a matching same-cycle CDB broadcast is forwarded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]     query_tag,
  input  logic [ROB_DEPTH-1:0] entry_valid,
  input  logic [ROB_DEPTH-1:0] entry_ready,
  input  logic [31:0]          entry_value [ROB_DEPTH],
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [31:0]          cdb_value,
  output logic                 query_ready,
  output logic [31:0]          query_value
);

  logic [IDX_W-1:0] w_idx;
  logic             w_hit;

  assign w_idx = tag_to_idx(query_tag);
  assign w_hit = tag_in_range(query_tag) && entry_valid[w_idx];

`ifdef ROB_CDB_FORWARD_EN
  logic w_fwd;

  assign w_fwd = w_hit && cdb_valid && (cdb_tag == query_tag);

  always_comb begin
    query_ready = 1'b0;
    query_value = '0;
    if (w_fwd) begin
      query_ready = 1'b1;
      query_value = cdb_value;
    end else if (w_hit) begin
      query_ready = entry_ready[w_idx];
      query_value = entry_value[w_idx];
    end
  end
`else
  logic w_unused_cdb;

  assign w_unused_cdb = ^{cdb_valid, cdb_tag, cdb_value};

  always_comb begin
    query_ready = 1'b0;
    query_value = '0;
    if (w_hit) begin
      query_ready = entry_ready[w_idx];
      query_value = entry_value[w_idx];
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order ROB: tag allocation, CDB capture, in-order retire
//            and mispredict flush. Optional ROB_CDB_FORWARD_EN adds CDB bypass
//            on the operand query ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             disp_valid,
  input  logic [4:0]       disp_rd,
  input  logic [1:0]       disp_type,
  output logic [TAG_W-1:0] disp_tag,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_redirect_pc,
  input  logic [TAG_W-1:0] query_tag_a,
  input  logic [TAG_W-1:0] query_tag_b,
  output logic             query_ready_a,
  output logic             query_ready_b,
  output logic [31:0]      query_value_a,
  output logic [31:0]      query_value_b,
  output logic             commit_valid,
  output logic [4:0]       commit_dest,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic             store_commit,
  output logic             wrong_commit,
  output logic [31:0]      flush_pc
);

  rob_entry_t       r_rob [ROB_DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  rob_entry_t       w_head;
  logic             w_head_done;
  logic             w_flush;
  logic             w_retire;
  logic             w_disp;
  logic             w_cdb_hit;
  logic [IDX_W-1:0] w_cdb_idx;

  logic [ROB_DEPTH-1:0] w_valid_vec;
  logic [ROB_DEPTH-1:0] w_ready_vec;
  logic [31:0]          w_value_vec [ROB_DEPTH];

  // Head state is sampled before this edge's CDB write, so a result lands
  // one cycle before it can retire.
  assign w_head      = r_rob[r_head];
  assign w_head_done = w_head.valid && w_head.ready;
  assign w_flush     = w_head_done && w_head.mispred && (w_head.typ == ROB_BR);
  assign w_retire    = w_head_done && !w_flush;

  assign rob_full  = (r_count == CNT_W'(ROB_DEPTH));
  assign disp_tag  = idx_to_tag(r_tail);
  assign w_disp    = disp_valid && !rob_full && !w_flush;
  assign w_cdb_idx = tag_to_idx(cdb_tag);
  assign w_cdb_hit = cdb_valid && tag_in_range(cdb_tag) && r_rob[w_cdb_idx].valid;

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_flat
      assign w_valid_vec[gi] = r_rob[gi].valid;
      assign w_ready_vec[gi] = r_rob[gi].ready;
      assign w_value_vec[gi] = r_rob[gi].value;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else if (rdy) begin
      if (w_flush) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          r_rob[i].valid <= 1'b0;
        end
      end else begin
        if (w_retire) begin
          r_rob[r_head].valid <= 1'b0;
        end
        if (w_cdb_hit) begin
          r_rob[w_cdb_idx].ready       <= 1'b1;
          r_rob[w_cdb_idx].value       <= cdb_value;
          r_rob[w_cdb_idx].mispred     <= cdb_mispredict;
          r_rob[w_cdb_idx].redirect_pc <= cdb_redirect_pc;
        end
        if (w_disp) begin
          r_rob[r_tail] <= '{valid: 1'b1, ready: 1'b0, mispred: 1'b0,
                             rd: disp_rd, typ: disp_type,
                             value: '0, redirect_pc: '0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_retire) begin
          r_head <= next_idx(r_head);
        end
        if (w_disp) begin
          r_tail <= next_idx(r_tail);
        end
        case ({w_disp, w_retire})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Valid/store/wrong pulses drop after one rdy-high cycle; data fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      wrong_commit <= 1'b0;
      commit_dest  <= '0;
      commit_tag   <= '0;
      commit_data  <= '0;
      flush_pc     <= '0;
    end else if (rdy) begin
      commit_valid <= w_head_done;
      store_commit <= w_retire && (w_head.typ == ROB_ST);
      wrong_commit <= w_flush;
      if (w_head_done) begin
        commit_tag  <= idx_to_tag(r_head);
        commit_data <= w_head.value;
        commit_dest <= (w_retire && (w_head.typ != ROB_ST)) ? w_head.rd : 5'd0;
      end
      if (w_flush) begin
        flush_pc <= w_head.redirect_pc;
      end
    end
  end

  rob_query_port u_query_a (
    .query_tag   (query_tag_a),
    .entry_valid (w_valid_vec),
    .entry_ready (w_ready_vec),
    .entry_value (w_value_vec),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .query_ready (query_ready_a),
    .query_value (query_value_a)
  );

  rob_query_port u_query_b (
    .query_tag   (query_tag_b),
    .entry_valid (w_valid_vec),
    .entry_ready (w_ready_vec),
    .entry_value (w_value_vec),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .query_ready (query_ready_b),
    .query_value (query_value_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Scoreboard bench for reorder_buffer (honours ROB_CDB_FORWARD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rdy;
  logic             disp_valid;
  logic [4:0]       disp_rd;
  logic [1:0]       disp_type;
  logic [TAG_W-1:0] disp_tag;
  logic             rob_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             cdb_mispredict;
  logic [31:0]      cdb_redirect_pc;
  logic [TAG_W-1:0] query_tag_a;
  logic [TAG_W-1:0] query_tag_b;
  logic             query_ready_a;
  logic             query_ready_b;
  logic [31:0]      query_value_a;
  logic [31:0]      query_value_b;
  logic             commit_valid;
  logic [4:0]       commit_dest;
  logic [TAG_W-1:0] commit_tag;
  logic [31:0]      commit_data;
  logic             store_commit;
  logic             wrong_commit;
  logic [31:0]      flush_pc;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_type(disp_type),
    .disp_tag(disp_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_redirect_pc(cdb_redirect_pc),
    .query_tag_a(query_tag_a), .query_tag_b(query_tag_b),
    .query_ready_a(query_ready_a), .query_ready_b(query_ready_b),
    .query_value_a(query_value_a), .query_value_b(query_value_b),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_data(commit_data), .store_commit(store_commit),
    .wrong_commit(wrong_commit), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        st;
    logic        wr;
    logic [31:0] fpc;
  } exp_t;

  exp_t        exp_q[$];
  logic [4:0]  pend_q[$];
  logic [31:0] plan_data  [32];
  logic        plan_mis   [32];
  logic [31:0] plan_redir [32];
  int          m_tail  = 0;
  int          m_count = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and score any commit produced by an enabled edge.
  task automatic tick();
    logic was_rdy;
    exp_t e;
    was_rdy = rdy;
    @(posedge clk);
    #1;
    if (was_rdy && rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_commit", {31'd0, commit_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_tag", {27'd0, commit_tag}, {27'd0, e.tag});
        chk("commit_dest", {27'd0, commit_dest}, {27'd0, e.dest});
        chk("commit_data", commit_data, e.data);
        chk("store_commit", {31'd0, store_commit}, {31'd0, e.st});
        chk("wrong_commit", {31'd0, wrong_commit}, {31'd0, e.wr});
        if (e.wr) begin
          chk("flush_pc", flush_pc, e.fpc);
          exp_q.delete();
          pend_q.delete();
          m_count = 0;
          m_tail  = 0;
        end else begin
          m_count--;
        end
      end
    end
  endtask

  task automatic cycle(input bit do_disp, input logic [4:0] rd, input logic [1:0] typ,
                       input logic [31:0] data, input bit mis, input logic [31:0] redir,
                       input bit do_cdb, input logic [4:0] ctag);
    int   t;
    bit   accept;
    exp_t e;
    t = m_tail + 1;
    accept = do_disp && (m_count < ROB_DEPTH);
    if (do_disp) begin
      chk("disp_tag", {27'd0, disp_tag}, t);
      chk("rob_full_pre", {31'd0, rob_full}, (m_count == ROB_DEPTH) ? 32'd1 : 32'd0);
      disp_valid = 1'b1;
      disp_rd    = rd;
      disp_type  = typ;
    end
    if (do_cdb) begin
      cdb_valid       = 1'b1;
      cdb_tag         = ctag;
      cdb_value       = plan_data[ctag];
      cdb_mispredict  = plan_mis[ctag];
      cdb_redirect_pc = plan_redir[ctag];
      for (int i = 0; i < pend_q.size(); i++) begin
        if (pend_q[i] == ctag) begin
          pend_q.delete(i);
          break;
        end
      end
    end
    tick();
    if (accept) begin
      plan_data[t]  = data;
      plan_mis[t]   = mis;
      plan_redir[t] = redir;
      e.tag  = t[4:0];
      e.wr   = (typ == ROB_BR) && mis;
      e.st   = (typ == ROB_ST);
      e.dest = (e.wr || e.st) ? 5'd0 : rd;
      e.data = data;
      e.fpc  = redir;
      exp_q.push_back(e);
      pend_q.push_back(t[4:0]);
      m_count++;
      m_tail = (m_tail + 1) % ROB_DEPTH;
    end
    disp_valid     = 1'b0;
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [1:0] typ, input logic [31:0] data,
                      input bit mis, input logic [31:0] redir);
    cycle(1'b1, rd, typ, data, mis, redir, 1'b0, 5'd0);
  endtask

  task automatic comp(input logic [4:0] tag);
    cycle(1'b0, 5'd0, ROB_ALU, 32'd0, 1'b0, 32'd0, 1'b1, tag);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, ROB_ALU, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (pend_q.size() > 0) comp(pend_q[0]);
      else if (exp_q.size() > 0) idle();
      else break;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tf, tbr;
    rst_n = 1'b0; rdy = 1'b1; disp_valid = 1'b0; disp_rd = '0; disp_type = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0;
    cdb_redirect_pc = '0; query_tag_a = 5'd1; query_tag_b = 5'd0;
    #12;
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_store_commit", {31'd0, store_commit}, 32'd0);
    chk("rst_wrong_commit", {31'd0, wrong_commit}, 32'd0);
    chk("rst_commit_dest", {27'd0, commit_dest}, 32'd0);
    chk("rst_commit_tag", {27'd0, commit_tag}, 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_rob_full", {31'd0, rob_full}, 32'd0);
    chk("rst_disp_tag", {27'd0, disp_tag}, 32'd1);
    chk("rst_query_a", {31'd0, query_ready_a}, 32'd0);
    rst_n = 1'b1;

    // Single ALU op: result captured, retired two edges after the CDB.
    disp(5'd5, ROB_ALU, 32'h1234, 1'b0, 32'd0);
    comp(5'd1);
    chk("t1_not_same_cycle", {31'd0, commit_valid}, 32'd0);
    idle();
    chk("t1_commit_seen", exp_q.size(), 32'd0);

    // Out-of-order completion, in-order retire.
    ta = m_tail + 1;
    disp(5'd7, ROB_ALU, 32'hA, 1'b0, 32'd0);
    tb = m_tail + 1;
    disp(5'd8, ROB_ALU, 32'hB, 1'b0, 32'd0);
    comp(tb[4:0]);
    idle();
    chk("t3_hold_young", {31'd0, commit_valid}, 32'd0);
    idle();
    chk("t3_hold_young2", {31'd0, commit_valid}, 32'd0);
    comp(ta[4:0]);
    idle();
    chk("t3_first_tag", {27'd0, commit_tag}, ta);
    idle();
    chk("t3_second_valid", {31'd0, commit_valid}, 32'd1);
    chk("t3_second_tag", {27'd0, commit_tag}, tb);

    // Fill, hold dispatch while full, free one slot.
    tf = m_tail + 1;
    for (int i = 0; i < ROB_DEPTH; i++) disp(5'(i + 1), ROB_ALU, 32'h100 + i, 1'b0, 32'd0);
    chk("t2_full", {31'd0, rob_full}, 32'd1);
    disp(5'd3, ROB_ALU, 32'hDEAD, 1'b0, 32'd0);
    chk("t2_tail_hold", {27'd0, disp_tag}, m_tail + 1);
    comp(tf[4:0]);
    chk("t2_full_after_cdb", {31'd0, rob_full}, 32'd1);
    idle();
    chk("t2_slot_freed", {31'd0, rob_full}, 32'd0);
    drain();

    // Mispredicted branch with three younger entries.
    tbr = m_tail + 1;
    disp(5'd3, ROB_BR, 32'h55, 1'b1, 32'h100);
    ta = m_tail + 1;
    disp(5'd4, ROB_ALU, 32'h44, 1'b0, 32'd0);
    disp(5'd6, ROB_ST, 32'h66, 1'b0, 32'd0);
    disp(5'd9, ROB_ALU, 32'h99, 1'b0, 32'd0);
    comp(ta[4:0]);
    comp(tbr[4:0]);
    idle();
    chk("t4_flush_done", exp_q.size(), 32'd0);
    chk("t4_not_full", {31'd0, rob_full}, 32'd0);
    chk("t4_tag_restart", {27'd0, disp_tag}, 32'd1);
    idle();
    idle();
    disp(5'd1, ROB_ALU, 32'h11, 1'b0, 32'd0);

    // Query with and without same-cycle forward.
    disp(5'd2, ROB_ALU, 32'h22, 1'b0, 32'd0);
    disp(5'd3, ROB_ALU, 32'd7, 1'b0, 32'd0);
    query_tag_a = 5'd3;
    query_tag_b = 5'd0;
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_value = 32'd7; cdb_mispredict = 1'b0;
    #1;
`ifdef ROB_CDB_FORWARD_EN
    chk("t5_fwd_ready", {31'd0, query_ready_a}, 32'd1);
    chk("t5_fwd_value", query_value_a, 32'd7);
`else
    chk("t5_nofwd_ready", {31'd0, query_ready_a}, 32'd0);
`endif
    chk("t5_tag0_ready", {31'd0, query_ready_b}, 32'd0);
    chk("t5_tag0_value", query_value_b, 32'd0);
    for (int i = 0; i < pend_q.size(); i++) begin
      if (pend_q[i] == 5'd3) begin
        pend_q.delete(i);
        break;
      end
    end
    tick();
    cdb_valid = 1'b0;
    query_tag_b = 5'd1;
    #1;
    chk("t5_ready_next", {31'd0, query_ready_a}, 32'd1);
    chk("t5_value_next", query_value_a, 32'd7);
    chk("t5_pending_b", {31'd0, query_ready_b}, 32'd0);
    drain();

    // Streaming across tag wrap with a 3-cycle rdy freeze.
    for (int i = 0; i < 24; i++) begin
      if (i == 10) begin
        rdy = 1'b0;
        disp_valid = 1'b1; disp_rd = 5'd9; disp_type = ROB_ALU;
        cdb_valid = 1'b1; cdb_tag = pend_q[0]; cdb_value = 32'hBAD;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("t6_freeze_tag", {27'd0, disp_tag}, m_tail + 1);
          chk("t6_freeze_full", {31'd0, rob_full}, (m_count == ROB_DEPTH) ? 32'd1 : 32'd0);
        end
        rdy = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0;
      end
      if (pend_q.size() >= 4)
        cycle(1'b1, 5'(i + 10), (i % 4 == 1) ? ROB_BR : (i % 4 == 2) ? ROB_ST : ROB_ALU,
              32'h5000 + i, 1'b0, 32'd0, 1'b1, pend_q[0]);
      else
        disp(5'(i + 10), (i % 4 == 1) ? ROB_BR : (i % 4 == 2) ? ROB_ST : ROB_ALU,
             32'h5000 + i, 1'b0, 32'd0);
    end
    drain();

    // Reset in the middle of traffic discards everything.
    disp(5'd12, ROB_ALU, 32'h77, 1'b0, 32'd0);
    disp(5'd13, ROB_ALU, 32'h78, 1'b0, 32'd0);
    comp(pend_q[0]);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_full", {31'd0, rob_full}, 32'd0);
    chk("t7_rst_tag", {27'd0, disp_tag}, 32'd1);
    chk("t7_rst_commit", {31'd0, commit_valid}, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    pend_q.delete();
    m_count = 0;
    m_tail  = 0;
    idle();
    idle();
    disp(5'd14, ROB_ALU, 32'h79, 1'b0, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
